// File: rtl/hnf_txrsp.sv
// HNF TXRSP channel: response flit queue with CHI link-layer credit flow control.
// Flits are queued, announced via txrspflitpend, then sent one cycle later when a credit is held.
package hnf_txrsp_pkg;
  typedef struct packed {
    logic [3:0] qos;
    logic [6:0] tgtid;
    logic [6:0] srcid;
    logic [7:0] txnid;
    logic [3:0] opcode;
    logic [1:0] resperr;
    logic [2:0] resp;
    logic [7:0] dbid;
  } rspflit_t;
endpackage

module hnf_txrsp
  import hnf_txrsp_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_LCRD = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [$bits(rspflit_t)-1:0] rsp_in,
  input  logic                 rsp_in_v,
  output logic                 rsp_in_rdy,
  output rspflit_t             txrspflit,
  output logic                 txrspflitv,
  output logic                 txrspflitpend,
  input  logic                 txrsplcrdv,
  output logic [3:0]           txrsp_lcrd_cnt,
  output logic                 txrsp_lcrd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]  MAX_CNT = 4'(MAX_LCRD);

  rspflit_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [3:0]    lcrd_cnt;
  logic [3:0]    lcrd_nxt;
  logic          err_set;
  logic          full;
  logic          empty;
  logic          push;
  logic          send_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready depends only on full so a same-cycle pop never opens a slot early.
  assign rsp_in_rdy     = ~full;
  assign push           = rsp_in_v & rsp_in_rdy;
  assign send_en        = txrspflitpend & ~empty & (lcrd_cnt != 4'd0);
  assign txrsp_lcrd_cnt = lcrd_cnt;

  always_comb begin
    lcrd_nxt = lcrd_cnt;
    err_set  = 1'b0;
    unique case ({txrsplcrdv, send_en})
      2'b10: begin
        if (lcrd_cnt == MAX_CNT) err_set = 1'b1;
        else                     lcrd_nxt = lcrd_cnt + 4'd1;
      end
      2'b01:   lcrd_nxt = lcrd_cnt - 4'd1;
      default: lcrd_nxt = lcrd_cnt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rspflit_t'(rsp_in);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      lcrd_cnt       <= '0;
      txrspflit      <= '0;
      txrspflitv     <= 1'b0;
      txrspflitpend  <= 1'b0;
      txrsp_lcrd_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (send_en) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        txrspflit  <= mem[rd_ptr[AW-1:0]];
        txrspflitv <= 1'b1;
      end else begin
        txrspflitv <= 1'b0;
      end
      txrspflitpend <= ~empty | rsp_in_v;
      lcrd_cnt      <= lcrd_nxt;
      if (err_set) txrsp_lcrd_err <= 1'b1;
    end
  end

endmodule
